// File: rtl/jtframe_i2s_pkg.sv
// Shared I2S definitions: receiver FSM encoding and channel identifiers.
// Used by the receiver RTL and by the bench's transmitter model.
package jtframe_i2s_pkg;

  localparam logic [0:0] ALIGN = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } ch_e;

  // LRCLK level that carries a given channel.
  function automatic logic lr_of(ch_e ch);
    return ch == CH_R;
  endfunction

endpackage

// File: rtl/jtframe_i2s_sync.sv
// SYNC-deep synchroniser for BCLK/LRCLK/SDATA plus a BCLK rising-edge detector.
module jtframe_i2s_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_data,
  output logic bclk_rise,
  output logic lr_s,
  output logic dat_s
);

  logic [SYNC-1:0] bclk_sr, lr_sr, dat_sr;
  logic            bclk_d;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sr <= '0;
      lr_sr   <= '0;
      dat_sr  <= '0;
      bclk_d  <= 1'b0;
    end else begin
      bclk_sr <= {bclk_sr[SYNC-2:0], i2s_bclk};
      lr_sr   <= {lr_sr[SYNC-2:0],   i2s_lrclk};
      dat_sr  <= {dat_sr[SYNC-2:0],  i2s_data};
      bclk_d  <= bclk_sr[SYNC-1];
    end
  end

  assign bclk_rise = bclk_sr[SYNC-1] & ~bclk_d;
  assign lr_s      = lr_sr[SYNC-1];
  assign dat_s     = dat_sr[SYNC-1];

endmodule

// File: rtl/jtframe_i2s_rx.sv
// I2S receiver: oversamples an external I2S stream on clk and delivers signed
// left/right PCM pairs with a one-cycle sample strobe.
module jtframe_i2s_rx
  import jtframe_i2s_pkg::*;
#(
  parameter int DW      = 16,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2s_bclk,
  input  logic          i2s_lrclk,
  input  logic          i2s_data,
  output logic [DW-1:0] snd_left,
  output logic [DW-1:0] snd_right,
  output logic          sample,
  output logic          locked,
  output logic          short_err
);

  localparam int BW = $clog2(DW+1);
  localparam int TW = $clog2(TIMEOUT+1);

  logic          bclk_rise, lr_s, dat_s;
  logic [0:0]    st;
  ch_e           ch;
  logic [BW-1:0] bitcnt, fin_cnt, shamt;
  logic [DW-1:0] sreg, fin_sreg, word, left_pend;
  logic [TW-1:0] tcnt;
  logic          lr_prev, lr_edge, full;

  jtframe_i2s_sync #(.SYNC(SYNC)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_data  (i2s_data),
    .bclk_rise (bclk_rise),
    .lr_s      (lr_s),
    .dat_s     (dat_s)
  );

  // The rise that shows the LRCLK edge carries the closing word's LSB, so it
  // completes that word (if room remains) rather than starting the next one.
  // NOTE: every always_comb output is assigned on all paths to avoid latches.
  always_comb begin
    full     = bitcnt == BW'(DW);
    fin_sreg = full ? sreg   : {sreg[DW-2:0], dat_s};
    fin_cnt  = full ? bitcnt : bitcnt + 1'b1;
    shamt    = BW'(DW) - fin_cnt;
    word     = fin_sreg << shamt;
    lr_edge  = lr_s != lr_prev;
  end

  // NOTE: the shift register and pending word are plain flops, so they are
  // cleared by reset like any other state; there is no memory array here.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ALIGN;
      ch        <= CH_L;
      bitcnt    <= '0;
      sreg      <= '0;
      left_pend <= '0;
      lr_prev   <= 1'b0;
      tcnt      <= '0;
      snd_left  <= '0;
      snd_right <= '0;
      sample    <= 1'b0;
      locked    <= 1'b0;
      short_err <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (bclk_rise) begin
        tcnt    <= '0;
        lr_prev <= lr_s;
        if (st == ALIGN) begin
          if (lr_edge && !lr_s) begin
            st     <= SHIFT;
            ch     <= CH_L;
            bitcnt <= '0;
            sreg   <= '0;
          end
        end else if (!lr_edge) begin
          if (!full) begin
            sreg   <= {sreg[DW-2:0], dat_s};
            bitcnt <= bitcnt + 1'b1;
          end
        end else if (lr_s == lr_of(ch)) begin
          // Edge towards the level we are already in: an LRCLK edge was lost.
          st     <= ALIGN;
          sreg   <= '0;
          bitcnt <= '0;
        end else begin
          if (fin_cnt < BW'(DW)) short_err <= 1'b1;
          sreg   <= '0;
          bitcnt <= '0;
          if (ch == CH_L) begin
            left_pend <= word;
            ch        <= CH_R;
          end else begin
            snd_left  <= left_pend;
            snd_right <= word;
            sample    <= 1'b1;
            locked    <= 1'b1;
            ch        <= CH_L;
          end
        end
      end else if (tcnt == TW'(TIMEOUT)) begin
        locked <= 1'b0;
        st     <= ALIGN;
        sreg   <= '0;
        bitcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule
